// File: rtl/ova_line_buf_pkg.sv
// Shared constants and types for the OV-camera line buffer.
package ova_line_buf_pkg;

    // Default geometry: a VGA line of RGB565 pixels per bank.
    localparam int OVA_LINE_W = 640;
    localparam int OVA_AW     = 10;
    localparam int OVA_DW     = 16;

    // Read-side sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } rd_state_e;

endpackage : ova_line_buf_pkg

// File: rtl/ova_line_ram.sv
// Simple dual-port line RAM: two banks of LINE_W words, addressed {bank, addr},
// with a registered (synchronous) read port that holds its value when not enabled.
module ova_line_ram #(
    parameter int LINE_W = 640,
    parameter int AW     = 10,
    parameter int DW     = 16
) (
    input  logic          i_pclk,
    input  logic          rst_n,
    input  logic          wr_en_i,
    input  logic [AW:0]   wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW:0]   rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2][LINE_W];
    logic [DW-1:0] rd_data_q;

    // Write port.
    // NOTE: the storage array has no reset so it maps onto block RAM; its contents are don't-care after reset.
    always_ff @(posedge i_pclk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i[AW]][wr_addr_i[AW-1:0]] <= wr_data_i;
        end
    end

    // Read port: registered output, held while rd_en_i is low so a stalled pixel stays put.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i[AW]][rd_addr_i[AW-1:0]];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : ova_line_ram

// File: rtl/ova_line_buf.sv
// Ping-pong line buffer between the camera capture stage and a valid/ready pixel stream.
// The writer fills the bank chosen by i_fifo_choose and commits it on each toggle or at
// frame end; the reader streams committed banks alternately, starting with bank 0.
module ova_line_buf
    import ova_line_buf_pkg::*;
#(
    parameter int LINE_W = OVA_LINE_W,  // max pixels per line per bank
    parameter int AW     = OVA_AW       // 2**AW must be >= LINE_W
) (
    input  logic        i_pclk,
    input  logic        rst_n,
    input  logic [15:0] i_data,
    input  logic        i_data_vld,
    input  logic        i_fifo_choose,
    input  logic        i_frame_en,
    output logic [15:0] o_pix_data,
    output logic        o_pix_vld,
    input  logic        i_pix_rdy,
    output logic        o_sol,
    output logic        o_eol,
    output logic [1:0]  o_bank_full,
    output logic        o_overflow
);

    // Counts reach LINE_W itself, so they carry one bit more than an address.
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] LINE_MAX = CW'(LINE_W);

    // Write-side state.
    logic          choose_q, frame_en_q;
    logic [CW-1:0] wr_cnt_q [2];
    logic [CW-1:0] wr_cnt_d [2];
    logic [CW-1:0] len_q    [2];
    logic [CW-1:0] len_d    [2];
    logic [1:0]    full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          toggle, frame_fall, frame_rise, commit, wr_en;

    // Read-side state.
    rd_state_e     state_q, state_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          last, rd_done, rd_en;
    logic [AW:0]   rd_addr;
    logic [AW:0]   wr_addr;

    assign toggle     = choose_q != i_fifo_choose;
    assign frame_fall = frame_en_q & ~i_frame_en;
    assign frame_rise = ~frame_en_q & i_frame_en;
    // The bank being filled is closed by a toggle or the end of the frame, never when empty.
    assign commit     = (toggle | frame_fall) && (wr_cnt_q[choose_q] != '0);
    assign wr_addr    = {i_fifo_choose, wr_cnt_q[i_fifo_choose][AW-1:0]};
    assign last       = idx_q == (len_q[rd_bank_q] - CW'(1));

    // Write-side next state: commit, release by the reader, pixel accept or drop.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        len_d      = len_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (commit) begin
            full_d[choose_q]   = 1'b1;
            len_d[choose_q]    = wr_cnt_q[choose_q];
            wr_cnt_d[choose_q] = '0;
        end
        // A release always targets the bank under read, which is never the one committing.
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (frame_rise) begin
            overflow_d = 1'b0;
        end
        // On a toggle cycle the pixel lands in the new bank, distinct from the committing one.
        if (i_data_vld && i_frame_en) begin
            if (full_q[i_fifo_choose] || (wr_cnt_q[i_fifo_choose] == LINE_MAX)) begin
                overflow_d = 1'b1;
            end else begin
                wr_en                   = 1'b1;
                wr_cnt_d[i_fifo_choose] = wr_cnt_q[i_fifo_choose] + CW'(1);
            end
        end
    end

    // Write-side registers.
    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            choose_q   <= 1'b0;
            frame_en_q <= 1'b0;
            wr_cnt_q   <= '{default: '0};
            len_q      <= '{default: '0};
            full_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            choose_q   <= i_fifo_choose;
            frame_en_q <= i_frame_en;
            wr_cnt_q   <= wr_cnt_d;
            len_q      <= len_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    // Read FSM state register.
    always_ff @(posedge i_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_bank_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            idx_q     <= idx_d;
        end
    end

    // Read FSM next state: wait for a full bank, one fetch cycle, then stream to the last pixel.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        idx_d     = idx_q;
        rd_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                end
            end
            ST_FETCH: state_d = ST_STREAM;
            ST_STREAM: begin
                if (i_pix_rdy) begin
                    if (last) begin
                        rd_done   = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        idx_d     = '0;
                        state_d   = full_q[~rd_bank_q] ? ST_FETCH : ST_IDLE;
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read FSM outputs: RAM read requests and stream sideband, all decoded from registers.
    always_comb begin
        rd_en     = 1'b0;
        rd_addr   = {rd_bank_q, AW'(0)};
        o_pix_vld = 1'b0;
        o_sol     = 1'b0;
        o_eol     = 1'b0;
        case (state_q)
            ST_FETCH: rd_en = 1'b1;
            ST_STREAM: begin
                // Prefetch the next word only when the current one is consumed.
                rd_en     = i_pix_rdy && !last;
                rd_addr   = {rd_bank_q, idx_q[AW-1:0] + AW'(1)};
                o_pix_vld = 1'b1;
                o_sol     = idx_q == '0;
                o_eol     = last;
            end
            default: ;
        endcase
    end

    ova_line_ram #(
        .LINE_W (LINE_W),
        .AW     (AW),
        .DW     (OVA_DW)
    ) u_ram (
        .i_pclk    (i_pclk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (i_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (o_pix_data)
    );

    assign o_bank_full = full_q;
    assign o_overflow  = overflow_q;

endmodule : ova_line_buf

// File: tb/tb_ova_line_buf.sv
// Scoreboard bench for ova_line_buf: stimulus pushes the expected pixel stream,
// a negedge monitor pops and compares on every handshake and checks stall stability.
module tb_ova_line_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] i_data;
    logic        i_data_vld;
    logic        i_fifo_choose;
    logic        i_frame_en;
    logic [15:0] o_pix_data;
    logic        o_pix_vld;
    logic        i_pix_rdy;
    logic        o_sol;
    logic        o_eol;
    logic [1:0]  o_bank_full;
    logic        o_overflow;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 1;  // 0: stall, 1: always ready, 2: random 50%

    logic [17:0] exp_q [$];   // {data, sol, eol}
    logic        stalled = 1'b0;
    logic [17:0] held;

    always #5 clk = ~clk;

    ova_line_buf dut (
        .i_pclk        (clk),
        .rst_n         (rst_n),
        .i_data        (i_data),
        .i_data_vld    (i_data_vld),
        .i_fifo_choose (i_fifo_choose),
        .i_frame_en    (i_frame_en),
        .o_pix_data    (o_pix_data),
        .o_pix_vld     (o_pix_vld),
        .i_pix_rdy     (i_pix_rdy),
        .o_sol         (o_sol),
        .o_eol         (o_eol),
        .o_bank_full   (o_bank_full),
        .o_overflow    (o_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pix(input int tag, input int i);
        return {tag[5:0], i[9:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n back-to-back pixels; the first n_exp of them are expected downstream.
    task automatic send_line(input int n, input int tag, input int n_exp);
        for (int i = 0; i < n; i++) begin
            i_data     = pix(tag, i);
            i_data_vld = 1'b1;
            if (i < n_exp) exp_q.push_back({pix(tag, i), i == 0, i == n_exp - 1});
            tick();
        end
        i_data_vld = 1'b0;
    endtask

    task automatic toggle();
        i_fifo_choose = ~i_fifo_choose;
        tick();
    endtask

    task automatic wait_drain(input int budget);
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < budget) begin
            tick();
            cnt++;
        end
        check("drain_timeout", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic wait_bank_free(input int budget);
        int cnt = 0;
        while (o_bank_full[i_fifo_choose] && cnt < budget) begin
            tick();
            cnt++;
        end
        check("bank_free_timeout", o_bank_full[i_fifo_choose], 0);
    endtask

    // Ready driver.
    initial begin
        i_pix_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_pix_rdy = 1'b0;
                1:       i_pix_rdy = 1'b1;
                default: i_pix_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare on handshake, check held values while stalled.
    always @(negedge clk) begin
        if (rst_n && o_pix_vld) begin
            if (stalled) check("pix_hold", {o_pix_data, o_sol, o_eol}, held);
            if (i_pix_rdy) begin
                check("pix_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("pix_data", {o_pix_data, o_sol, o_eol}, exp_q.pop_front());
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = {o_pix_data, o_sol, o_eol};
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Watchdog.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int lens [6] = '{5, 17, 1, 30, 2, 12};

        rst_n         = 1'b0;
        i_data        = '0;
        i_data_vld    = 1'b0;
        i_fifo_choose = 1'b0;
        i_frame_en    = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_vld", o_pix_vld, 0);
        check("rst_sol_eol", {o_sol, o_eol}, 0);
        check("rst_full", o_bank_full, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_data", o_pix_data, 0);
        rst_n      = 1'b1;
        i_frame_en = 1'b1;
        tick();

        // 4-pixel line to bank 0, toggle, stream with ready high.
        send_line(4, 1, 4);
        toggle();
        check("t1_full_commit", o_bank_full, 2'b01);
        lat = 0;
        while (!o_pix_vld && lat < 10) begin
            tick();
            lat++;
        end
        check("t1_latency", lat, 2);
        wait_drain(50);
        check("t1_full_after", o_bank_full, 2'b00);

        // Two full lines with ready low, third line overflows.
        rdy_mode = 0;
        send_line(640, 2, 640);    // bank 1 (reader is on bank 1)
        toggle();
        send_line(640, 3, 640);    // bank 0
        toggle();
        check("t2_full_both", o_bank_full, 2'b11);
        check("t2_no_ovf_yet", o_overflow, 0);
        send_line(10, 4, 0);       // bank 1 still full: all dropped
        check("t2_ovf", o_overflow, 1);
        toggle();                  // empty lines: no commit
        toggle();
        check("t2_full_kept", o_bank_full, 2'b11);
        rdy_mode = 1;
        wait_drain(3000);
        check("t2_full_after", o_bank_full, 2'b00);
        i_frame_en = 1'b0;
        tick();
        i_frame_en = 1'b1;
        tick();
        check("t2_ovf_cleared", o_overflow, 0);

        // Zero-length toggles commit nothing.
        toggle();
        toggle();
        tick();
        check("zero_len_full", o_bank_full, 2'b00);
        check("zero_len_vld", o_pix_vld, 0);

        // 700-pixel line: only 640 kept, eol on pixel 639.
        send_line(700, 5, 640);    // bank 1
        toggle();
        check("t3_ovf", o_overflow, 1);
        wait_drain(1000);
        check("t3_full_after", o_bank_full, 2'b00);

        // Frame end commits a 3-pixel line; frame start clears overflow.
        send_line(3, 6, 3);        // bank 0
        i_frame_en = 1'b0;
        tick();
        check("t5_full_on_fall", o_bank_full, 2'b01);
        check("t5_ovf_sticky", o_overflow, 1);
        wait_drain(50);
        i_frame_en = 1'b1;
        tick();
        check("t5_ovf_cleared", o_overflow, 0);
        toggle();                  // realign writer with reader (bank 1)

        // Random backpressure over several lines, including a 1-pixel line.
        rdy_mode = 2;
        for (int l = 0; l < 6; l++) begin
            wait_bank_free(2000);
            send_line(lens[l], 10 + l, lens[l]);
            toggle();
        end
        wait_drain(2000);
        rdy_mode = 1;
        tick();
        check("t4_full_after", o_bank_full, 2'b00);
        check("t4_no_ovf", o_overflow, 0);

        // Reset in the middle of a streamed line.
        send_line(40, 20, 40);
        toggle();
        lat = 0;
        while (!o_pix_vld && lat < 10) begin
            tick();
            lat++;
        end
        check("t6_stream_started", o_pix_vld, 1);
        repeat (3) tick();
        #2;
        rst_n         = 1'b0;
        i_fifo_choose = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_vld", o_pix_vld, 0);
        check("t6_rst_full", o_bank_full, 2'b00);
        check("t6_rst_sol_eol", {o_sol, o_eol}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_line(6, 21, 6);       // bank 0
        toggle();
        check("t6_full_commit", o_bank_full, 2'b01);
        wait_drain(50);
        check("t6_full_after", o_bank_full, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ova_line_buf

// File: doc/ova_line_buf.md
OVA_LINE_BUF -- requirements
Module: ova_line_buf

Interface
REQ-001 SHALL have parameter LINE_W, default 640, meaning the maximum pixels per line per bank.
REQ-002 SHALL have parameter AW, default 10, meaning the address width; it SHALL satisfy 2^AW >= LINE_W.
REQ-003 SHALL have port i_pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_data, input, 16 bits: the RGB565 pixel from the capture stage.
REQ-006 SHALL have port i_data_vld, input, 1 bit: a single-cycle pixel strobe.
REQ-007 SHALL have port i_fifo_choose, input, 1 bit: the write-bank select, which toggles once per line end.
REQ-008 SHALL have port i_frame_en, input, 1 bit: the capture window; it is the vsync-derived work enable.
REQ-009 SHALL have port o_pix_data, output, 16 bits: the streamed pixel.
REQ-010 SHALL have port o_pix_vld, output, 1 bit: the stream valid.
REQ-011 SHALL have port i_pix_rdy, input, 1 bit: the stream ready.
REQ-012 SHALL have port o_sol, output, 1 bit: asserted with the first pixel of a line.
REQ-013 SHALL have port o_eol, output, 1 bit: asserted with the last pixel of a line.
REQ-014 SHALL have port o_bank_full, output, 2 bits: per-bank committed-line flags.
REQ-015 SHALL have port o_overflow, output, 1 bit: a sticky error flag, cleared on each i_frame_en rising edge.

Function
REQ-016 SHALL write i_data into bank i_fifo_choose at address wr_cnt[bank] when i_data_vld=1 and i_frame_en=1, then increment wr_cnt.
REQ-017 SHALL register i_fifo_choose; when the registered value differs from i_fifo_choose, it SHALL commit the old bank: full=1, len=wr_cnt, wr_cnt=0.
REQ-018 SHALL commit the old bank in that same cycle if a pixel arrives on the toggle cycle, and SHALL write that pixel to the new bank at address 0.
REQ-019 SHALL commit a toggle only if wr_cnt>0; a zero-length line SHALL NOT set full.
REQ-020 SHALL drop the pixel and set o_overflow when a write finds wr_cnt==LINE_W; the line still commits with len=LINE_W.
REQ-021 SHALL drop all pixels and set o_overflow when a write targets a bank with full=1; that bank's contents and len SHALL remain intact.
REQ-022 SHALL commit the active bank on an i_frame_en falling edge if wr_cnt>0.
REQ-023 SHALL implement the read FSM states IDLE, FETCH and STREAM.
REQ-024 SHALL move IDLE->FETCH when bank full[rd_bank]=1.
REQ-025 SHALL spend exactly one cycle in FETCH for the synchronous RAM read, then move to STREAM.
REQ-026 SHALL hold o_pix_data, o_sol and o_eol stable while o_pix_vld=1 and i_pix_rdy=0.
REQ-027 SHALL deliver back-to-back pixels at one per cycle while i_pix_rdy=1.
REQ-028 SHALL have a first-pixel latency from commit to o_pix_vld of 2 cycles.
REQ-029 SHALL, on the handshake of the o_eol pixel, clear full[rd_bank], toggle rd_bank, and go to IDLE, or to FETCH if the other bank is full.
REQ-030 SHALL assert o_sol and o_eol together for a line with len=1.
REQ-031 SHALL permit a commit on one bank and a release on the other in the same cycle.
REQ-032 SHALL NOT allow the read side to stream a bank whose full flag is 0.

Reset
REQ-033 SHALL, on rst_n=0 at any time, asynchronously clear the following: wr_cnt, len, full, rd_bank=0, FSM=IDLE, o_pix_vld=0, o_sol=0, o_eol=0, o_overflow=0, o_pix_data=0, registered choose=0.
REQ-034 SHALL discard any line in flight at reset; RAM contents are don't-care.

Structure
REQ-035 SHALL place the FSM state encodings and the default LINE_W/AW constants in the shared ova package.
REQ-036 SHALL use one sub-module, ova_line_ram, a simple dual-port 2*LINE_W x 16 synchronous-read RAM addressed {bank, addr}.

Verification
REQ-037 SHALL cover a 4-pixel line to bank 0, toggle, with i_pix_rdy=1: 4 pixels out in order starting 2 cycles after commit, o_sol on pixel 0, o_eol on pixel 3, then full=00.
REQ-038 SHALL cover two 640-pixel lines with i_pix_rdy=0: o_bank_full=11; a third line sets o_overflow=1; releasing rdy outputs the first two lines intact.
REQ-039 SHALL cover a 700-pixel line: 640 pixels streamed, o_eol on pixel 639, o_overflow=1.
REQ-040 SHALL cover random i_pix_rdy backpressure at 50%: data identical to the input sequence, no duplicates, outputs held stable while stalled.
REQ-041 SHALL cover i_frame_en falling after 3 pixels without a toggle: a 3-pixel line is streamed; an i_frame_en rising edge clears o_overflow.
REQ-042 SHALL cover rst_n asserted mid-STREAM: o_pix_vld=0 immediately, o_bank_full=00, and the next line streams from bank 0 correctly.
